// File: rtl/fifo_uart_pkg.sv
// Shared FSM encoding and line levels for the FIFO-to-UART drain stage.
// FIFO_UART_TX_PARITY_EN adds the PARITY state to the encoding.
package fifo_uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    LOAD,
    START,
    DATA,
`ifdef FIFO_UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } tx_state_t;

  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 and wraps. tc marks the last cycle of a bit.
// pre_tc marks the cycle before it, so registered outputs can line up with the last cycle.
module uart_baud_cnt #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clock,
  input  logic rst,
  input  logic clear,
  output logic tc,
  output logic pre_tc
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] PRE  = CW'(CLKS_PER_BIT - 2);

  logic [CW-1:0] cnt;

  assign tc     = (cnt == LAST);
  assign pre_tc = (cnt == PRE);

  always_ff @(posedge clock) begin
    if (rst || clear) begin
      cnt <= '0;
    end else if (tc) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/fifo_uart_tx.sv
// Drains the byte FIFO into 8N1 UART frames; tx_serial falls 2 cycles after a non-empty IDLE cycle.
// Reads only when tx_en && !fifo_empty in IDLE; FIFO_UART_TX_PARITY_EN inserts an even-parity bit.
module fifo_uart_tx
  import fifo_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8
) (
  input  logic                 clock,
  input  logic                 rst,
  input  logic                 tx_en,
  input  logic                 fifo_empty,
  input  logic [DATA_BITS-1:0] fifo_data,
  output logic                 fifo_rd,
  output logic                 tx_serial,
  output logic                 busy,
  output logic                 tx_done
);

  localparam int IW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [IW-1:0] LAST_BIT = IW'(DATA_BITS - 1);

  tx_state_t            state;
  logic [DATA_BITS-1:0] shift_reg;
  logic [IW-1:0]        bit_idx;
  logic                 tc;
  logic                 pre_tc;
  logic                 baud_clear;

  // Holding the counter at zero until START makes the start bit exactly one bit period long.
  assign baud_clear = (state == IDLE) || (state == REQ) || (state == LOAD);

  uart_baud_cnt #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clock (clock),
    .rst   (rst),
    .clear (baud_clear),
    .tc    (tc),
    .pre_tc(pre_tc)
  );

  always_ff @(posedge clock) begin
    if (rst) begin
      state     <= IDLE;
      tx_serial <= LINE_IDLE;
      fifo_rd   <= 1'b0;
      busy      <= 1'b0;
      tx_done   <= 1'b0;
      shift_reg <= '0;
      bit_idx   <= '0;
    end else begin
      tx_done <= 1'b0;
      case (state)
        IDLE: begin
          if (tx_en && !fifo_empty) begin
            state   <= REQ;
            fifo_rd <= 1'b1;
            busy    <= 1'b1;
          end
        end
        REQ: begin
          fifo_rd <= 1'b0;
          state   <= LOAD;
        end
        LOAD: begin
          shift_reg <= fifo_data;
          tx_serial <= START_BIT;
          state     <= START;
        end
        START: begin
          if (tc) begin
            state     <= DATA;
            bit_idx   <= '0;
            tx_serial <= shift_reg[0];
          end
        end
        DATA: begin
          if (tc) begin
            if (bit_idx == LAST_BIT) begin
`ifdef FIFO_UART_TX_PARITY_EN
              state     <= PARITY;
              tx_serial <= ^shift_reg;
`else
              state     <= STOP;
              tx_serial <= STOP_BIT;
`endif
            end else begin
              bit_idx   <= bit_idx + IW'(1);
              tx_serial <= shift_reg[bit_idx + IW'(1)];
            end
          end
        end
`ifdef FIFO_UART_TX_PARITY_EN
        PARITY: begin
          if (tc) begin
            state     <= STOP;
            tx_serial <= STOP_BIT;
          end
        end
`endif
        STOP: begin
          // tx_done is registered, so it is raised one cycle early to land on the final stop cycle.
          if (tc) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (pre_tc) begin
            tx_done <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench for fifo_uart_tx at CLKS_PER_BIT=4, with a registered-read byte FIFO model.
module tb_fifo_uart_tx;

  localparam int CPB = 4;
`ifdef FIFO_UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FLEN = NBITS * CPB;

  logic       clock = 1'b0;
  logic       rst = 1'b1;
  logic       tx_en = 1'b0;
  logic       fifo_empty;
  logic [7:0] fifo_data = 8'h00;
  logic       fifo_rd;
  logic       tx_serial;
  logic       busy;
  logic       tx_done;

  logic       wr = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic [7:0] fmem [16];
  int         wp = 0;
  int         rp = 0;
  int         fcount = 0;

  int rd_cnt = 0;
  int done_cnt = 0;
  int rd_while_empty = 0;
  int rd_double = 0;
  logic prev_rd = 1'b0;

  int vectors = 0;
  int miscompares = 0;

  always #5 clock = ~clock;

  fifo_uart_tx #(
    .CLKS_PER_BIT(CPB),
    .DATA_BITS   (8)
  ) dut (
    .clock     (clock),
    .rst       (rst),
    .tx_en     (tx_en),
    .fifo_empty(fifo_empty),
    .fifo_data (fifo_data),
    .fifo_rd   (fifo_rd),
    .tx_serial (tx_serial),
    .busy      (busy),
    .tx_done   (tx_done)
  );

  assign fifo_empty = (fcount == 0);

  always @(posedge clock) begin
    if (fifo_rd === 1'b1) begin
      rd_cnt <= rd_cnt + 1;
      if (fcount == 0) begin
        rd_while_empty <= rd_while_empty + 1;
      end else begin
        fifo_data <= fmem[rp];
        rp <= (rp + 1) % 16;
      end
      if (prev_rd === 1'b1) rd_double <= rd_double + 1;
    end
    if (wr) begin
      fmem[wp] <= wr_data;
      wp <= (wp + 1) % 16;
    end
    fcount <= fcount + (wr ? 1 : 0) - (((fifo_rd === 1'b1) && fcount != 0) ? 1 : 0);
    if (tx_done === 1'b1) done_cnt <= done_cnt + 1;
    prev_rd <= fifo_rd;
  end

  task automatic push(input logic [7:0] b);
    wr = 1'b1;
    wr_data = b;
    @(negedge clock);
    wr = 1'b0;
  endtask

  // Counts the idle-high samples seen before the start bit, including the current one.
  task automatic wait_start(output bit found, output int gap);
    found = 1'b0;
    gap = 0;
    for (int i = 0; i < 300; i++) begin
      if (tx_serial === 1'b0) begin
        found = 1'b1;
        break;
      end
      gap++;
      @(negedge clock);
    end
  endtask

  task automatic check_frame(input logic [7:0] b, input string name, input int drop_at,
                             output int gap);
    logic exp_bits [11];
    bit   found;
    int   bad_bit, bad_done, bad_busy;
    logic got_bit;
    exp_bits[0] = 1'b0;
    for (int k = 0; k < 8; k++) exp_bits[k+1] = b[k];
`ifdef FIFO_UART_TX_PARITY_EN
    exp_bits[9]  = ^b;
    exp_bits[10] = 1'b1;
`else
    exp_bits[9]  = 1'b1;
    exp_bits[10] = 1'b1;
`endif
    wait_start(found, gap);
    vectors++;
    if (!found) begin
      miscompares++;
      $display("FAIL %s start: no start bit within 300 cycles, required one", name);
      return;
    end
    bad_bit = -1;
    bad_done = -1;
    bad_busy = -1;
    got_bit = 1'b0;
    for (int cyc = 0; cyc < FLEN; cyc++) begin
      if (cyc > 0) @(negedge clock);
      if (cyc == drop_at) tx_en = 1'b0;
      if (bad_bit < 0 && tx_serial !== exp_bits[cyc/CPB]) begin
        bad_bit = cyc;
        got_bit = tx_serial;
      end
      if (bad_done < 0 && tx_done !== (cyc == FLEN - 1)) bad_done = cyc;
      if (bad_busy < 0 && busy !== 1'b1) bad_busy = cyc;
    end
    vectors++;
    if (bad_bit >= 0) begin
      miscompares++;
      $display("FAIL %s bits: cycle %0d tx_serial=%b required %b", name, bad_bit, got_bit,
               exp_bits[bad_bit/CPB]);
    end
    vectors++;
    if (bad_done >= 0) begin
      miscompares++;
      $display("FAIL %s tx_done: wrong at frame cycle %0d, required high only at cycle %0d",
               name, bad_done, FLEN - 1);
    end
    vectors++;
    if (bad_busy >= 0) begin
      miscompares++;
      $display("FAIL %s busy: low at frame cycle %0d, required high", name, bad_busy);
    end
    @(negedge clock);
    vectors++;
    if ({tx_serial, busy, tx_done} !== 3'b100) begin
      miscompares++;
      $display("FAIL %s end: {tx_serial,busy,tx_done}=%b required 100", name,
               {tx_serial, busy, tx_done});
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tx_en = 1'b0;
    repeat (3) @(negedge clock);
    vectors++;
    if (tx_serial !== 1'b1) begin
      miscompares++; $display("FAIL reset tx_serial: got %b required 1", tx_serial);
    end
    vectors++;
    if (fifo_rd !== 1'b0) begin
      miscompares++; $display("FAIL reset fifo_rd: got %b required 0", fifo_rd);
    end
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++; $display("FAIL reset busy: got %b required 0", busy);
    end
    vectors++;
    if (tx_done !== 1'b0) begin
      miscompares++; $display("FAIL reset tx_done: got %b required 0", tx_done);
    end
    rst = 1'b0;
    push(8'hA5);
    repeat (20) @(negedge clock);
    vectors++;
    if (rd_cnt !== 0) begin
      miscompares++; $display("FAIL en_low rd: %0d reads with tx_en=0, required 0", rd_cnt);
    end
    vectors++;
    if (busy !== 1'b0 || tx_serial !== 1'b1) begin
      miscompares++;
      $display("FAIL en_low idle: busy=%b tx_serial=%b required 0/1", busy, tx_serial);
    end
  endtask

  task automatic test_single_byte();
    int rd_base, done_base, gap;
    rd_base = rd_cnt;
    done_base = done_cnt;
    tx_en = 1'b1;
    @(negedge clock);
    vectors++;
    if (fifo_rd !== 1'b1 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL single req: fifo_rd=%b busy=%b required 1/1", fifo_rd, busy);
    end
    @(negedge clock);
    vectors++;
    if (fifo_rd !== 1'b0 || tx_serial !== 1'b1) begin
      miscompares++;
      $display("FAIL single load: fifo_rd=%b tx_serial=%b required 0/1", fifo_rd, tx_serial);
    end
    check_frame(8'hA5, "single", -1, gap);
    vectors++;
    if (rd_cnt - rd_base !== 1) begin
      miscompares++; $display("FAIL single rd: %0d pulses required 1", rd_cnt - rd_base);
    end
    vectors++;
    if (done_cnt - done_base !== 1) begin
      miscompares++; $display("FAIL single done: %0d pulses required 1", done_cnt - done_base);
    end
    vectors++;
    if (fifo_empty !== 1'b1) begin
      miscompares++; $display("FAIL single empty: fifo_empty=%b required 1", fifo_empty);
    end
  endtask

  task automatic test_back_to_back();
    int rd_base, g0, g1, g2;
    rd_base = rd_cnt;
    push(8'h00);
    push(8'hFF);
    push(8'h3C);
    check_frame(8'h00, "b2b_0", -1, g0);
    check_frame(8'hFF, "b2b_1", -1, g1);
    vectors++;
    if (g1 < 3) begin
      miscompares++; $display("FAIL b2b gap1: %0d idle cycles required >= 3", g1);
    end
    check_frame(8'h3C, "b2b_2", -1, g2);
    vectors++;
    if (g2 < 3) begin
      miscompares++; $display("FAIL b2b gap2: %0d idle cycles required >= 3", g2);
    end
    repeat (5) @(negedge clock);
    vectors++;
    if (rd_cnt - rd_base !== 3) begin
      miscompares++; $display("FAIL b2b rd: %0d pulses required 3", rd_cnt - rd_base);
    end
    vectors++;
    if (rd_while_empty !== 0 || rd_double !== 0) begin
      miscompares++;
      $display("FAIL b2b rd_rules: empty-reads=%0d long-strobes=%0d required 0/0",
               rd_while_empty, rd_double);
    end
  endtask

  task automatic test_tx_en_drop();
    int rd_base, gap, lat;
    rd_base = rd_cnt;
    push(8'h55);
    push(8'h66);
    check_frame(8'h55, "en_drop", 10, gap);
    repeat (20) @(negedge clock);
    vectors++;
    if (rd_cnt - rd_base !== 1 || fifo_empty !== 1'b0) begin
      miscompares++;
      $display("FAIL en_drop hold: %0d reads empty=%b required 1 read, empty 0",
               rd_cnt - rd_base, fifo_empty);
    end
    tx_en = 1'b1;
    lat = 99;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clock);
      if (fifo_rd === 1'b1) begin
        lat = i;
        break;
      end
    end
    vectors++;
    if (lat > 3) begin
      miscompares++; $display("FAIL en_resume: fifo_rd after %0d cycles required <= 3", lat);
    end
    check_frame(8'h66, "en_resume", -1, gap);
  endtask

  task automatic test_reset_mid_frame();
    int  rd_base, gap;
    bit  found;
    rd_base = rd_cnt;
    push(8'hC3);
    push(8'h81);
    wait_start(found, gap);
    vectors++;
    if (!found) begin
      miscompares++; $display("FAIL rst_mid start: no start bit within 300 cycles");
      return;
    end
    repeat (17) @(negedge clock);
    vectors++;
    if (tx_serial !== 1'b0) begin
      miscompares++; $display("FAIL rst_mid bit3: tx_serial=%b required 0", tx_serial);
    end
    rst = 1'b1;
    @(negedge clock);
    rst = 1'b0;
    vectors++;
    if (tx_serial !== 1'b1 || busy !== 1'b0 || fifo_rd !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_mid abort: tx_serial=%b busy=%b fifo_rd=%b required 1/0/0",
               tx_serial, busy, fifo_rd);
    end
    check_frame(8'h81, "rst_next", -1, gap);
    vectors++;
    if (rd_cnt - rd_base !== 2) begin
      miscompares++; $display("FAIL rst_mid rd: %0d pulses required 2", rd_cnt - rd_base);
    end
  endtask

`ifdef FIFO_UART_TX_PARITY_EN
  task automatic test_parity();
    int gap;
    push(8'h07);
    check_frame(8'h07, "parity_07", -1, gap);
  endtask
`endif

  initial begin
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_tx_en_drop();
    test_reset_mid_frame();
`ifdef FIFO_UART_TX_PARITY_EN
    test_parity();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
